pcm_frame_writer: RTL

PCM_FRAME_WRITER -- requirements
Module: pcm_frame_writer

---
 rtl/pcm_writer_pkg.sv | 23 ++
 rtl/pcm_sample_latch.sv | 62 ++++++
 rtl/pcm_frame_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pcm_writer_pkg.sv
// Shared types and constants for the PCM frame writer: FSM encoding, sample width
// and the values exchanged with the host through the flag word.
package pcm_writer_pkg;

  localparam int unsigned SAMPLE_W = 16;

  // Flag word holds the completed half plus one, so zero means "host has consumed it".
  localparam logic [31:0] FLAG_CLEAR = 32'd0;
  localparam logic [31:0] FLAG_BASE  = 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_FLAG,
    S_POLL,
    S_CHECK
  } state_t;

  function automatic int unsigned words_per_frame(input int unsigned mic_n);
    return (mic_n + 1) / 2;
  endfunction

endpackage

// File: rtl/pcm_sample_latch.sv
// One-deep hold register in front of a work register, plus the mux that packs two
// 16-bit channels into each 32-bit RAM word (odd channel counts pad the top half with 0).
module pcm_sample_latch
  import pcm_writer_pkg::*;
#(
  parameter int unsigned mic_n  = 2,
  parameter int unsigned wsel_w = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [mic_n*SAMPLE_W-1:0] sample_data,
  input  logic                      sample_valid,
  input  logic                      load,
  input  logic [wsel_w-1:0]         word_sel,
  output logic                      hold_full,
  output logic                      overrun,
  output logic [31:0]               word
);

  localparam int unsigned Wpf  = words_per_frame(mic_n);
  localparam int unsigned PadW = Wpf * 32;

  logic [mic_n*SAMPLE_W-1:0] hold_q, work_q;
  logic                      full_q;
  logic                      capture;
  logic [PadW-1:0]           work_pad;

  // Freeing the hold and a new arrival in the same cycle still captures the arrival.
  assign capture = sample_valid && (!full_q || load);
  assign overrun = sample_valid && full_q && !load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      hold_q <= '0;
      work_q <= '0;
    end else begin
      if (capture) begin
        hold_q <= sample_data;
        full_q <= 1'b1;
      end else if (load) begin
        full_q <= 1'b0;
      end
      if (load) begin
        work_q <= hold_q;
      end
    end
  end

  assign work_pad  = PadW'(work_q);
  assign hold_full = full_q;

  always_comb begin
    word = '0;
    for (int i = 0; i < int'(Wpf); i++) begin
      if (word_sel == wsel_w'(i)) begin
        word = work_pad[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/pcm_frame_writer.sv
// Writes multichannel PCM frames into a double-buffered RAM region and signals each
// completed half through a flag word. Define PCM_FRAME_WRITER_STATS_EN for overrun_count.
module pcm_frame_writer
  import pcm_writer_pkg::*;
#(
  parameter int unsigned mic_n            = 2,
  parameter int unsigned frames_per_block = 16,
  parameter int unsigned addr_w           = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [mic_n*SAMPLE_W-1:0] sample_data,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic [addr_w-1:0]         address,
  output logic                      chipselect,
  output logic                      write,
  output logic [31:0]               writedata,
  input  logic [31:0]               readdata,
  output logic [3:0]                byteenable,
  output logic                      irq,
  output logic                      active_half
`ifdef PCM_FRAME_WRITER_STATS_EN
  ,
  output logic [15:0]               overrun_count
`endif
);

  localparam int unsigned Wpf       = words_per_frame(mic_n);
  localparam int unsigned WselW     = (Wpf > 1) ? $clog2(Wpf) : 1;
  localparam int unsigned FidxW     = (frames_per_block > 1) ? $clog2(frames_per_block) : 1;
  localparam int unsigned HalfWords = frames_per_block * Wpf;
  localparam logic [addr_w-1:0] FlagAddr = '1;

  if (2 * frames_per_block * Wpf > 2 ** addr_w - 1) begin : g_size_check
    $error("pcm_frame_writer: both buffer halves must fit below the flag word");
  end

  state_t             state_q, state_d;
  logic [FidxW-1:0]   frame_q, frame_d;
  logic [WselW-1:0]   wsel_q, wsel_d;
  logic               half_q, half_d;
  logic               irq_q, irq_d;
  logic               load, hold_full, hold_ovr, flag_ovr, done_half;
  logic [31:0]        word;

  pcm_sample_latch #(
    .mic_n  (mic_n),
    .wsel_w (WselW)
  ) u_latch (
    .clk          (clk),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .load         (load),
    .word_sel     (wsel_q),
    .hold_full    (hold_full),
    .overrun      (hold_ovr),
    .word         (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      wsel_q  <= '0;
      half_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      wsel_q  <= wsel_d;
      half_q  <= half_d;
      irq_q   <= irq_d;
    end
  end

  // active_half has already toggled by the time S_FLAG runs.
  assign done_half = ~half_q;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    wsel_d     = wsel_q;
    half_d     = half_q;
    irq_d      = irq_q;
    load       = 1'b0;
    flag_ovr   = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          wsel_d  = '0;
          state_d = S_WR;
        end else if (irq_q) begin
          state_d = S_POLL;
        end
      end
      S_WR: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = addr_w'(32'(half_q) * HalfWords + 32'(frame_q) * Wpf + 32'(wsel_q));
        writedata  = word;
        if (wsel_q == WselW'(Wpf - 1)) begin
          wsel_d = '0;
          if (frame_q == FidxW'(frames_per_block - 1)) begin
            frame_d = '0;
            half_d  = ~half_q;
            state_d = S_FLAG;
          end else begin
            frame_d = frame_q + FidxW'(1);
            state_d = S_IDLE;
          end
        end else begin
          wsel_d = wsel_q + WselW'(1);
        end
      end
      S_FLAG: begin
        if (!irq_q) begin
          chipselect = 1'b1;
          write      = 1'b1;
          address    = FlagAddr;
          writedata  = FLAG_BASE + 32'(done_half);
          irq_d      = 1'b1;
        end else begin
          flag_ovr = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_POLL: begin
        chipselect = 1'b1;
        address    = FlagAddr;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (readdata == FLAG_CLEAR) begin
          irq_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sample_ready = ~hold_full;
  assign byteenable   = 4'b1111;
  assign irq          = irq_q;
  assign active_half  = half_q;

`ifdef PCM_FRAME_WRITER_STATS_EN
  logic [16:0] ovr_sum;
  assign ovr_sum = {1'b0, overrun_count} + 17'(hold_ovr) + 17'(flag_ovr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_count <= '0;
    end else begin
      overrun_count <= ovr_sum[16] ? 16'hffff : ovr_sum[15:0];
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = hold_ovr ^ flag_ovr;
`endif

endmodule
